// File: rtl/hb_dec_stream_fifo.sv
// Stream FIFO behind the half-band decimator: it captures strobed samples and drops them on
// overflow, because the decimator cannot stall. Defining HB_FIFO_DROP_CNT_EN adds drop_cnt.
module hb_dec_stream_fifo #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
`ifdef HB_FIFO_DROP_CNT_EN
    output logic [15:0]              drop_cnt,
`endif
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned FrameW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [PtrW-1:0]   PtrOne    = 1;
    localparam logic [PtrW:0]     LevelOne  = 1;
    localparam logic [PtrW:0]     LevelFull = DEPTH[PtrW:0];
    localparam logic [FrameW-1:0] FrameOne  = 1;
    localparam logic [FrameW-1:0] FrameMax  = FrameW'(FRAME_LEN - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     level_q, level_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
    logic              ovf_q, ovf_d;

    logic rd_fire;
    logic full;
    logic wr_en;
    logic drop;

    assign out_valid = (level_q != '0);
    assign rd_fire   = out_valid && out_ready;
    assign full      = (level_q == LevelFull);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en     = in_valid && (!full || rd_fire);
    assign drop      = in_valid && full && !rd_fire;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_fire) begin
            rd_ptr_d    = rd_ptr_q + PtrOne;
            frame_cnt_d = (frame_cnt_q == FrameMax) ? '0 : frame_cnt_q + FrameOne;
        end

        unique case ({wr_en, rd_fire})
            2'b10:   level_d = level_q + LevelOne;
            2'b01:   level_d = level_q - LevelOne;
            default: level_d = level_q;
        endcase

        // Set wins over clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset; level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last = out_valid && (frame_cnt_q == FrameMax);
    assign level    = level_q;
    assign ovf      = ovf_q;

`ifdef HB_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
